// File: rtl/ooo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ooo_pkg
// Brief   : Shared types and default widths for the out-of-order core
//           writeback path (common data bus).
// Revision: 1.0 - initial release
// ============================================================================
package ooo_pkg;

  // Default widths shared by the reservation station and the CDB arbiter
  localparam int CDB_TAG_WIDTH  = 5;
  localparam int CDB_DATA_WIDTH = 32;

  // One writeback packet as carried on the common data bus
  typedef struct packed {
    logic [CDB_TAG_WIDTH-1:0]  tag;
    logic [CDB_DATA_WIDTH-1:0] data;
  } cdb_pkt_t;

endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Round-robin arbiter. Scans from the priority pointer upward with
//           wrap-around; the winner becomes lowest priority next cycle.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  logic [IDX_W-1:0] rr_ptr;
  logic             found;

  // Index reached after stepping k places from base, modulo NUM_REQ
  function automatic int wrap_idx(input int base, input int k);
    return (base + k >= NUM_REQ) ? base + k - NUM_REQ : base + k;
  endfunction

  // Priority scan starting at rr_ptr; first valid requester wins
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[wrap_idx(int'(rr_ptr), k)]) begin
        found     = 1'b1;
        grant_idx = IDX_W'(wrap_idx(int'(rr_ptr), k));
      end
    end
  end

  assign grant_any = found && en;

  // One-hot grant, suppressed entirely when disabled
  always_comb begin
    grant = '0;
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  // Pointer moves just past the winner; holds when nothing is granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : cdb_arbiter
// Brief   : Shares the single CDB writeback port among NUM_REQ execution
//           units. Round-robin grant, registered broadcast, flush support and
//           a saturating contention counter.
// Revision: 1.0 - initial release
// ============================================================================
module cdb_arbiter
  import ooo_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = CDB_DATA_WIDTH,
  parameter int TAG_WIDTH  = CDB_TAG_WIDTH,
  parameter int CNT_WIDTH  = 16,
  localparam int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ-1:0][TAG_WIDTH-1:0]    req_tag,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic                                 flush,
  output logic                                 wb_valid,
  output logic [TAG_WIDTH-1:0]                 wb_tag,
  output logic [DATA_WIDTH-1:0]                wb_data,
  output logic [IDX_W-1:0]                     wb_src,
  output logic [CNT_WIDTH-1:0]                 conflict_cnt
);

  // Packet layout matches cdb_pkt_t but follows this instance's widths
  typedef struct packed {
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } pkt_t;

  logic [IDX_W-1:0] winner;
  logic             transfer;
  logic             multi_req;
  pkt_t             sel_pkt;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .en        (!flush),
    .grant     (req_ready),
    .grant_idx (winner),
    .grant_any (transfer)
  );

  // Winner's packet; only consumed when a transfer happens
  always_comb begin
    sel_pkt.tag  = req_tag[winner];
    sel_pkt.data = req_data[winner];
  end

  // Two or more requesters: clearing the lowest set bit leaves something
  assign multi_req = |(req_valid & (req_valid - NUM_REQ'(1)));

  // Broadcast register: valid pulses one cycle, payload holds otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_tag   <= '0;
      wb_data  <= '0;
      wb_src   <= '0;
    end else begin
      wb_valid <= transfer;
      if (transfer) begin
        wb_tag  <= sel_pkt.tag;
        wb_data <= sel_pkt.data;
        wb_src  <= winner;
      end
    end
  end

  // Contention counter, saturating at all-ones, frozen during flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (multi_req && !flush && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_cdb_arbiter
// Brief   : Self-checking bench for cdb_arbiter (NUM_REQ=4 and NUM_REQ=3).
// Revision: 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

  localparam int N    = 4;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]         rv;
  logic [N-1:0][4:0]    rtag;
  logic [N-1:0][31:0]   rdata;
  logic [N-1:0]         rdy;
  logic                 fl;
  logic                 wbv;
  logic [4:0]           wbt;
  logic [31:0]          wbd;
  logic [1:0]           wbs;
  logic [CW-1:0]        cnt;

  logic [2:0]           rv3;
  logic [2:0][4:0]      rtag3;
  logic [2:0][31:0]     rdata3;
  logic [2:0]           rdy3;
  logic                 wbv3;
  logic [4:0]           wbt3;
  logic [31:0]          wbd3;
  logic [1:0]           wbs3;
  logic [15:0]          cnt3;

  cdb_arbiter #(.NUM_REQ(N), .DATA_WIDTH(32), .TAG_WIDTH(5), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(rv), .req_tag(rtag), .req_data(rdata),
    .req_ready(rdy), .flush(fl), .wb_valid(wbv), .wb_tag(wbt), .wb_data(wbd),
    .wb_src(wbs), .conflict_cnt(cnt));

  cdb_arbiter #(.NUM_REQ(3), .DATA_WIDTH(32), .TAG_WIDTH(5), .CNT_WIDTH(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv3), .req_tag(rtag3), .req_data(rdata3),
    .req_ready(rdy3), .flush(1'b0), .wb_valid(wbv3), .wb_tag(wbt3), .wb_data(wbd3),
    .wb_src(wbs3), .conflict_cnt(cnt3));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0] rv;
    logic       fl;
    logic [3:0] rdy;
    logic       wbv;
    logic [1:0] src;
    int         cnt;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic [3:0] v, input logic f, input logic [3:0] r,
                     input logic w, input logic [1:0] s, input int c);
    vec_t e;
    e.rv = v; e.fl = f; e.rdy = r; e.wbv = w; e.src = s; e.cnt = c;
    vt.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rv = '0; rv3 = '0; fl = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [4:0]  tag_c  [N];
  logic [31:0] data_c [N];

  // Reference-model state (random phase)
  bit          pend [N];
  logic [4:0]  ptag [N];
  logic [31:0] pdat [N];
  int          m_ptr, m_cnt, m_src, w, npend;
  bit          m_wbv, found;
  logic [4:0]  m_tag;
  logic [31:0] m_data;
  logic [3:0]  exp_rdy;

  initial begin
    rv = '0; fl = 1'b0; rv3 = '0;
    for (int i = 0; i < N; i++) begin
      tag_c[i] = 5'(5 + i);
      rtag[i]  = tag_c[i];
    end
    data_c[0] = 32'h1111_0000; data_c[1] = 32'h2222_0001;
    data_c[2] = 32'hDEAD_BEEF; data_c[3] = 32'h4444_0003;
    for (int i = 0; i < N; i++) rdata[i] = data_c[i];
    for (int i = 0; i < 3; i++) begin
      rtag3[i] = 5'(20 + i); rdata3[i] = 32'hC0DE_0000 + 32'(i);
    end

    // Idle, all-four rotation, single request, flush, post-flush grant
    for (int i = 0; i < 5; i++) add(4'b0000, 0, 4'b0000, 0, 0, 0);
    add(4'b1111, 0, 4'b0001, 0, 0, 0);
    add(4'b1111, 0, 4'b0010, 1, 0, 1);
    add(4'b1111, 0, 4'b0100, 1, 1, 2);
    add(4'b1111, 0, 4'b1000, 1, 2, 3);
    add(4'b1111, 0, 4'b0001, 1, 3, 4);
    add(4'b1111, 0, 4'b0010, 1, 0, 5);
    add(4'b1111, 0, 4'b0100, 1, 1, 6);
    add(4'b1111, 0, 4'b1000, 1, 2, 7);
    add(4'b0000, 0, 4'b0000, 1, 3, 8);
    add(4'b0100, 0, 4'b0100, 0, 3, 8);
    add(4'b0000, 0, 4'b0000, 1, 2, 8);
    add(4'b0000, 0, 4'b0000, 0, 2, 8);
    add(4'b1001, 1, 4'b0000, 0, 2, 8);
    add(4'b1001, 0, 4'b1000, 0, 2, 8);
    add(4'b0001, 0, 4'b0001, 1, 3, 9);
    add(4'b0000, 0, 4'b0000, 1, 0, 9);
    add(4'b0000, 0, 4'b0000, 0, 0, 9);

    do_reset();
    foreach (vt[i]) begin
      @(negedge clk);
      rv = vt[i].rv; fl = vt[i].fl;
      #1;
      chk($sformatf("tbl%0d_ready", i), 64'(rdy), 64'(vt[i].rdy));
      chk($sformatf("tbl%0d_wb_valid", i), 64'(wbv), 64'(vt[i].wbv));
      chk($sformatf("tbl%0d_wb_src", i), 64'(wbs), 64'(vt[i].src));
      chk($sformatf("tbl%0d_cnt", i), 64'(cnt), 64'(vt[i].cnt));
      if (vt[i].wbv) begin
        chk($sformatf("tbl%0d_wb_tag", i), 64'(wbt), 64'(tag_c[vt[i].src]));
        chk($sformatf("tbl%0d_wb_data", i), 64'(wbd), 64'(data_c[vt[i].src]));
      end
    end

    // Asynchronous reset while a broadcast is on the bus
    @(negedge clk); rv = 4'b1111; fl = 1'b0;
    @(negedge clk); #1;
    chk("rst_pre_wb_valid", 64'(wbv), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_wb_valid", 64'(wbv), 64'd0);
    chk("rst_async_cnt", 64'(cnt), 64'd0);
    chk("rst_async_wb_src", 64'(wbs), 64'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rst_first_grant", 64'(rdy), 64'b0001);
    @(negedge clk); #1;
    chk("rst_first_wb_src", 64'(wbs), 64'd0);
    chk("rst_first_wb_valid", 64'(wbv), 64'd1);

    // Saturation with a steady two-requester stream
    do_reset();
    for (int j = 0; j <= 70; j++) begin
      @(negedge clk); rv = 4'b0011; #1;
      if (j == 62 || j == 63 || j == 70)
        chk($sformatf("sat_cnt_j%0d", j), 64'(cnt), 64'(j > CMAX ? CMAX : j));
    end

    // NUM_REQ=3: units 1 and 2 alternate, index 3 never appears
    do_reset();
    for (int j = 0; j < 4; j++) begin
      @(negedge clk); rv3 = 3'b110; #1;
      chk($sformatf("n3_ready%0d", j), 64'(rdy3), (j % 2 == 0) ? 64'b010 : 64'b100);
      if (j > 0) begin
        chk($sformatf("n3_src%0d", j), 64'(wbs3), (j % 2 == 1) ? 64'd1 : 64'd2);
        chk($sformatf("n3_tag%0d", j), 64'(wbt3), (j % 2 == 1) ? 64'd21 : 64'd22);
      end
    end
    @(negedge clk); rv3 = 3'b000;

    // Randomized traffic against a queue-free behavioural model
    do_reset();
    m_ptr = 0; m_cnt = 0; m_src = 0; m_wbv = 0; m_tag = '0; m_data = '0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1; ptag[i] = 5'($urandom); pdat[i] = $urandom;
        end
        rv[i] = pend[i]; rtag[i] = ptag[i]; rdata[i] = pdat[i];
      end
      fl = ($urandom_range(0, 7) == 0);
      // Winner: nearest pending unit at or after the priority pointer
      found = 0; w = 0; npend = 0;
      for (int k = 0; k < N; k++) begin
        if (pend[(m_ptr + k) % N] && !found) begin found = 1; w = (m_ptr + k) % N; end
        if (pend[k]) npend++;
      end
      exp_rdy = (found && !fl) ? 4'(1 << w) : 4'b0000;
      #1;
      chk("rnd_ready", 64'(rdy), 64'(exp_rdy));
      chk("rnd_wb_valid", 64'(wbv), 64'(m_wbv));
      chk("rnd_wb_tag", 64'(wbt), 64'(m_tag));
      chk("rnd_wb_data", 64'(wbd), 64'(m_data));
      chk("rnd_wb_src", 64'(wbs), 64'(m_src));
      chk("rnd_cnt", 64'(cnt), 64'(m_cnt));
      if (npend >= 2 && !fl && m_cnt < CMAX) m_cnt++;
      if (found && !fl) begin
        m_wbv = 1; m_tag = ptag[w]; m_data = pdat[w]; m_src = w;
        m_ptr = (w + 1) % N; pend[w] = 0;
      end else begin
        m_wbv = 0;
      end
    end

    @(negedge clk); rv = '0; fl = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cdb_arbiter.md
# cdb_arbiter

- Shares the single writeback (common data bus) port of `reservation_station` (`wb_valid`/`wb_tag`/`wb_data`) among up to NUM_REQ execution units.
- Each cycle it picks at most one requesting unit using round-robin priority.
- The winner's tag and data are registered onto the broadcast bus for one cycle.
- Provides flush support and a saturating contention counter for performance monitoring.

## Interface

Parameters:
- NUM_REQ, 4, number of execution units requesting writeback (2..16, need not be a power of two)
- DATA_WIDTH, 32, result width
- TAG_WIDTH, 5, producer tag width; matches the reservation station TAG_WIDTH
- CNT_WIDTH, 16, contention counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  unit i has a result pending
- req_tag  in  NUM_REQ x TAG_WIDTH  tag of unit i's result
- req_data  in  NUM_REQ x DATA_WIDTH  data of unit i's result
- req_ready  out  NUM_REQ  one-hot grant; unit i's result is accepted this cycle
- flush  in  1  pipeline flush; suppresses grants and kills the pending broadcast
- wb_valid  out  1  broadcast valid (registered)
- wb_tag  out  TAG_WIDTH  broadcast tag (registered)
- wb_data  out  DATA_WIDTH  broadcast data (registered)
- wb_src  out  $clog2(NUM_REQ)  index of the unit that produced the current broadcast
- conflict_cnt  out  CNT_WIDTH  saturating count of cycles with two or more req_valid and no flush

## Operation

- Priority pointer rr_ptr ranges over 0..NUM_REQ-1.
- Selection:
  - Scan indices rr_ptr, rr_ptr+1, …, wrapping modulo NUM_REQ.
  - The first index with req_valid set wins.
  - Selection is combinational from req_valid and rr_ptr.
- req_ready[i] = (i == winner) && any req_valid && !flush. At most one bit is set.
- A transfer occurs for unit i when req_valid[i] && req_ready[i].
- Requester rules:
  - Once req_valid is asserted, the unit holds valid, tag and data stable until ready is seen.
  - Dropping valid before ready is a protocol violation; behaviour is unspecified.
- On a transfer:
  - wb_valid <= 1, wb_tag <= req_tag[winner], wb_data <= req_data[winner], wb_src <= winner.
  - rr_ptr <= winner+1, wrapping to 0 when winner == NUM_REQ-1.
- No transfer: wb_valid <= 0. wb_tag, wb_data and wb_src hold their previous values. rr_ptr holds.
- Flush:
  - In the flush cycle, req_ready = 0 and wb_valid <= 0.
  - The wb_valid registered in the previous cycle is still visible during the flush cycle; the consumer handles it.
  - rr_ptr holds; conflict_cnt does not increment.
- conflict_cnt:
  - Increments by 1 when popcount(req_valid) >= 2 and !flush.
  - Saturates at all-ones.
- Reset values: wb_valid 0, wb_tag 0, wb_data 0, wb_src 0, rr_ptr 0, conflict_cnt 0. req_ready is combinational: 0 whenever req_valid is 0.
- An asynchronous reset asserted mid-operation drops any in-flight broadcast. Units re-present their results after reset.

## Timing

- Latency: a result accepted in cycle N appears on wb_* in cycle N+1, valid for exactly one cycle.
- Throughput: one broadcast per cycle, sustained.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles of asserting valid.
- A requester that wins is the lowest priority on the next cycle. With all requesters valid, grants rotate 0,1,…,NUM_REQ-1,0.
- Combinational path req_valid -> req_ready: one priority scan of depth NUM_REQ. There is no path from input to wb_*.

## Structure

- Shared package `ooo_pkg`:
  - `cdb_pkt_t` packed struct {tag, data}, used by this block and by the reservation station writeback inputs.
  - Default TAG_WIDTH and DATA_WIDTH constants.
- Sub-module `rr_arbiter`, parameterised on NUM_REQ:
  - Inputs: req vector, enable (= !flush).
  - Outputs: one-hot grant, encoded grant index, any-grant.
  - Owns rr_ptr and updates it on grant.
- Top level: packet mux, output register, contention counter.

## Test plan

- Reset, then req_valid=0000 for 5 cycles -> req_ready=0000, wb_valid=0, conflict_cnt=0.
- Single request: unit 2 valid with tag 7, data 0xDEADBEEF in cycle N -> req_ready=0100 in N; wb_valid=1, wb_tag=7, wb_data=0xDEADBEEF, wb_src=2 in N+1; wb_valid=0 in N+2.
- All four units valid and held for 8 cycles -> grants 0,1,2,3,0,1,2,3 in order; conflict_cnt=8 after those cycles (once fewer than two remain valid, counting stops).
- NUM_REQ=3 wrap: units 1 and 2 hold valid -> grants 1,2,1,2 in order; rr_ptr wraps 2 -> 0 without ever selecting the absent unit index 3.
- flush asserted in the cycle with units 0 and 3 valid -> req_ready=0000, wb_valid=0 next cycle, conflict_cnt unchanged. The next cycle without flush grants the same unit that would have won.
- rst_n asserted while wb_valid=1 and req_valid=1111 -> wb_valid=0 immediately. After release, the first grant goes to unit 0. conflict_cnt is preloaded near all-ones via a forced 2-request stream and is checked to saturate, not wrap.
